seg7_readback: RTL and testbench
================================

SEG7_READBACK -- requirements
Module: seg7_readback

Interface
REQ-001 Parameter STABLE_COUNT, default 3, number of consecutive identical legal samples (range 1..15) that confirms a reading.
REQ-002 Parameter CHANGE_ONLY, default 1, when 1 a confirmed reading is emitted only if it differs from the last emitted value.
REQ-003 clock  input  1  single clock, all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 sample_en  input  1  one-cycle strobe, meaning the HEX inputs are sampled this cycle.
REQ-006 HEX5..HEX0  input  7 each  active-low segment codes, bit[6:0] = segments a..g, 0 = lit. HEX5/HEX4 carry the byte nibbles [7:4]/[3:0], and HEX3..HEX0 carry the halfword nibbles [15:12]..[3:0].
REQ-007 out_ready  input  1  consumer accepts the reading when it is high together with out_valid.
REQ-008 out_valid  output  1  confirmed reading is available.
REQ-009 pc_byte  output  8  decoded HEX5:HEX4.
REQ-010 wd_half  output  16  decoded HEX3:HEX0.
REQ-011 err  output  1  sticky flag: an illegal or blank code was sampled.
REQ-012 err_digit  output  6  sticky, one bit per digit (bit5 = HEX5), set for each digit that sampled an illegal or blank code.
REQ-013 overrun  output  1  sticky flag: a confirmed reading was dropped because out_valid was still pending.
REQ-014 clr_flags  input  1  synchronous clear of err, err_digit and overrun.

Function
REQ-015 The legal code table SHALL be exactly as follows:
- 0=0000001, 1=1001111, 2=0010010, 3=0000110
- 4=1001100, 5=0100100, 6=0100000, 7=0001111
- 8=0000000, 9=0001100, A=0001000, B=1100000
- C=0110001, D=1000010, E=0110000, F=0111000
- blank = 1111111
REQ-016 Any code other than 0..F (blank included) SHALL be illegal.
REQ-017 On a sample_en with all six codes legal, the block SHALL compare the 42-bit code vector against the last sampled vector (prev).
- If equal, stab_cnt SHALL increment, saturating at STABLE_COUNT.
- Otherwise stab_cnt SHALL be set to 1 and prev SHALL be loaded.
REQ-018 On a sample_en with any code illegal:
- stab_cnt SHALL be cleared to 0 and prev SHALL be invalidated.
- err and the matching err_digit bits SHALL be set.
- No capture SHALL occur.
REQ-019 A cycle without sample_en SHALL leave prev and stab_cnt unchanged.
REQ-020 State machine states are COLLECT and HOLD; reset enters COLLECT.
REQ-021 In COLLECT, when the sample_en that brings stab_cnt to STABLE_COUNT occurs, the block SHALL load the decoded value into pc_byte/wd_half, set out_valid and enter HOLD, all at that same clock edge.
- Exception: when CHANGE_ONLY=1 and the value equals the last emitted value, no capture occurs and the block stays in COLLECT.
- The first reading after reset is always emitted.
REQ-022 Further identical samples at saturation SHALL NOT re-trigger a capture; a new capture requires a changed vector to reach STABLE_COUNT again.
REQ-023 In HOLD, out_valid and the outputs SHALL stay stable until out_valid&&out_ready; at that edge out_valid drops and the state returns to COLLECT.
REQ-024 If a new confirmation occurs in HOLD, overrun SHALL be set, the new value SHALL be discarded, and the held value SHALL stay unchanged.
REQ-025 If out_ready and a new confirmation fall on the same edge in HOLD, the handshake SHALL complete and the new value SHALL be loaded with out_valid kept high; overrun is not set.
REQ-026 If clr_flags and a new error fall on the same edge, the new error SHALL win (flags set).
REQ-027 The "last emitted" register SHALL update on capture, not on handshake.

Reset
REQ-028 Asserting reset SHALL asynchronously force:
- state=COLLECT, out_valid=0, pc_byte=0, wd_half=0;
- err=0, err_digit=0, overrun=0;
- stab_cnt=0, prev invalid, last-emitted invalid.
REQ-029 Reset mid-HOLD SHALL drop out_valid immediately without requiring a handshake.

Structure
REQ-030 The shared package seg7_pkg SHALL hold the 17 segment code constants, the 7-bit segment code type and the state enumeration.
REQ-031 One combinational sub-module, seg7_to_hex (7-bit code in, 4-bit nibble and legal flag out), SHALL be instantiated six times.

Verification
REQ-032 Codes for 1,C,B,E,E,F, each held for 3 sample_en pulses -> out_valid rises at the 3rd sampled edge with pc_byte=8'h1C, wd_half=16'hBEEF, and stays until out_ready.
REQ-033 HEX0 changes to 0 after 2 stable samples, then 3 more samples -> exactly one capture with wd_half=16'hBEE0; no earlier capture.
REQ-034 HEX3=1111111 on one sample -> err=1, err_digit=6'b001000, stab_cnt restarts, and the next capture needs 3 fresh samples.
REQ-035 With CHANGE_ONLY=1, value 0x1C/0xBEEF confirmed again after a handshake -> no second out_valid; with CHANGE_ONLY=0 -> second out_valid.
REQ-036 out_ready=0 while a different value 0x20/0x1234 is confirmed -> overrun=1 and held outputs remain 0x1C/0xBEEF. Repeating with out_ready=1 on the confirming edge -> outputs become 0x20/0x1234, out_valid stays 1, overrun=0.
REQ-037 reset pulsed between clock edges during HOLD -> out_valid, pc_byte, wd_half and all flags read 0 before the next rising edge.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment readback block: the segment code
// type, the sixteen legal digit codes plus the blank code, and the state
// enumeration of the capture state machine.
// Segment codes are active-low, bit[6:0] = segments a..g, 0 = lit.
package seg7_pkg;

  typedef logic [6:0] seg_code_t;

  localparam seg_code_t SEG_0     = 7'b0000001;
  localparam seg_code_t SEG_1     = 7'b1001111;
  localparam seg_code_t SEG_2     = 7'b0010010;
  localparam seg_code_t SEG_3     = 7'b0000110;
  localparam seg_code_t SEG_4     = 7'b1001100;
  localparam seg_code_t SEG_5     = 7'b0100100;
  localparam seg_code_t SEG_6     = 7'b0100000;
  localparam seg_code_t SEG_7     = 7'b0001111;
  localparam seg_code_t SEG_8     = 7'b0000000;
  localparam seg_code_t SEG_9     = 7'b0001100;
  localparam seg_code_t SEG_A     = 7'b0001000;
  localparam seg_code_t SEG_B     = 7'b1100000;
  localparam seg_code_t SEG_C     = 7'b0110001;
  localparam seg_code_t SEG_D     = 7'b1000010;
  localparam seg_code_t SEG_E     = 7'b0110000;
  localparam seg_code_t SEG_F     = 7'b0111000;
  localparam seg_code_t SEG_BLANK = 7'b1111111;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

endpackage

// File: rtl/seg7_to_hex.sv
// Combinational decoder from one active-low segment code to a hex nibble.
// Ports:
//   code   - 7-bit segment code (bit6 = a ... bit0 = g, 0 = lit)
//   nibble - decoded value 0..F (0 when the code is not a digit)
//   legal  - 1 when the code is one of the sixteen digit shapes
// The blank code and every other pattern report legal = 0.
module seg7_to_hex
  import seg7_pkg::*;
(
  input  seg_code_t   code,
  output logic [3:0]  nibble,
  output logic        legal
);

  // Table lookup; anything outside the digit table is illegal.
  always_comb begin
    nibble = 4'h0;
    legal  = 1'b1;
    case (code)
      SEG_0:   nibble = 4'h0;
      SEG_1:   nibble = 4'h1;
      SEG_2:   nibble = 4'h2;
      SEG_3:   nibble = 4'h3;
      SEG_4:   nibble = 4'h4;
      SEG_5:   nibble = 4'h5;
      SEG_6:   nibble = 4'h6;
      SEG_7:   nibble = 4'h7;
      SEG_8:   nibble = 4'h8;
      SEG_9:   nibble = 4'h9;
      SEG_A:   nibble = 4'hA;
      SEG_B:   nibble = 4'hB;
      SEG_C:   nibble = 4'hC;
      SEG_D:   nibble = 4'hD;
      SEG_E:   nibble = 4'hE;
      SEG_F:   nibble = 4'hF;
      default: legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_readback.sv
// Reads six seven-segment digit codes back into binary values. A reading is
// confirmed after STABLE_COUNT consecutive identical legal samples and is
// then presented on a valid/ready output.
// Ports:
//   clock, reset        - rising-edge clock, asynchronous active-high reset
//   sample_en           - the HEX inputs are sampled on this cycle
//   HEX5..HEX0          - active-low codes; HEX5:HEX4 byte, HEX3..HEX0 halfword
//   out_ready           - consumer accepts the reading with out_valid
//   out_valid           - a confirmed reading is held on pc_byte / wd_half
//   pc_byte, wd_half    - decoded readings
//   err, err_digit      - sticky: an illegal/blank code was sampled (per digit)
//   overrun             - sticky: a confirmation was dropped while holding
//   clr_flags           - synchronous clear of err, err_digit and overrun
module seg7_readback
  import seg7_pkg::*;
#(
  parameter int STABLE_COUNT = 3,
  parameter bit CHANGE_ONLY  = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sample_en,
  input  logic [6:0]  HEX5,
  input  logic [6:0]  HEX4,
  input  logic [6:0]  HEX3,
  input  logic [6:0]  HEX2,
  input  logic [6:0]  HEX1,
  input  logic [6:0]  HEX0,
  input  logic        out_ready,
  input  logic        clr_flags,
  output logic        out_valid,
  output logic [7:0]  pc_byte,
  output logic [15:0] wd_half,
  output logic        err,
  output logic [5:0]  err_digit,
  output logic        overrun
);

  localparam logic [3:0] STABLE_C = STABLE_COUNT[3:0];

  seg_code_t   code_s [6];
  logic [3:0]  nib_s  [6];
  logic [5:0]  legal_s;
  logic [41:0] vec_s;
  logic [23:0] value_s;
  logic        sample_ok_s;
  logic        sample_bad_s;
  logic        same_s;
  logic [3:0]  cnt_next_s;
  logic        confirm_s;
  logic        fresh_s;
  logic        overrun_ev_s;

  logic [41:0] prev_r;
  logic        prev_valid_r;
  logic [3:0]  stab_cnt_r;
  logic [23:0] last_r;
  logic        last_valid_r;
  state_t      state_r;
  logic        out_valid_r;
  logic [7:0]  pc_byte_r;
  logic [15:0] wd_half_r;
  logic        err_r;
  logic [5:0]  err_digit_r;
  logic        overrun_r;

  // Index i of code_s / nib_s / legal_s corresponds to HEXi.
  assign code_s[5] = HEX5;
  assign code_s[4] = HEX4;
  assign code_s[3] = HEX3;
  assign code_s[2] = HEX2;
  assign code_s[1] = HEX1;
  assign code_s[0] = HEX0;

  for (genvar g = 0; g < 6; g++) begin : g_dec
    seg7_to_hex u_dec (
      .code   (code_s[g]),
      .nibble (nib_s[g]),
      .legal  (legal_s[g])
    );
  end

  assign vec_s   = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};
  assign value_s = {nib_s[5], nib_s[4], nib_s[3], nib_s[2], nib_s[1], nib_s[0]};

  assign sample_ok_s  = sample_en && (&legal_s);
  assign sample_bad_s = sample_en && !(&legal_s);
  assign same_s       = prev_valid_r && (vec_s == prev_r);

  // Next stability count for a legal sample, saturating at STABLE_COUNT.
  always_comb begin
    if (!same_s) begin
      cnt_next_s = 4'd1;
    end else if (stab_cnt_r == STABLE_C) begin
      cnt_next_s = STABLE_C;
    end else begin
      cnt_next_s = stab_cnt_r + 4'd1;
    end
  end

  // Only the sample that first reaches the threshold confirms; samples that
  // merely stay saturated do not.
  assign confirm_s    = sample_ok_s && (cnt_next_s == STABLE_C) &&
                        !(same_s && (stab_cnt_r == STABLE_C));
  assign fresh_s      = confirm_s &&
                        (!CHANGE_ONLY || !last_valid_r || (value_s != last_r));
  assign overrun_ev_s = fresh_s && (state_r == HOLD) && !out_ready;

  // Stability tracker: last sampled vector and its run length.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_r       <= 42'd0;
      prev_valid_r <= 1'b0;
      stab_cnt_r   <= 4'd0;
    end else if (sample_ok_s) begin
      if (!same_s) begin
        prev_r <= vec_s;
      end else begin
        prev_r <= prev_r;
      end
      prev_valid_r <= 1'b1;
      stab_cnt_r   <= cnt_next_s;
    end else if (sample_bad_s) begin
      prev_valid_r <= 1'b0;
      stab_cnt_r   <= 4'd0;
    end else begin
      prev_valid_r <= prev_valid_r;
      stab_cnt_r   <= stab_cnt_r;
    end
  end

  // Capture state machine with registered outputs and last-emitted value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r      <= COLLECT;
      out_valid_r  <= 1'b0;
      pc_byte_r    <= 8'd0;
      wd_half_r    <= 16'd0;
      last_r       <= 24'd0;
      last_valid_r <= 1'b0;
    end else begin
      case (state_r)
        COLLECT: begin
          if (fresh_s) begin
            pc_byte_r    <= value_s[23:16];
            wd_half_r    <= value_s[15:0];
            last_r       <= value_s;
            last_valid_r <= 1'b1;
            out_valid_r  <= 1'b1;
            state_r      <= HOLD;
          end else begin
            state_r <= COLLECT;
          end
        end
        HOLD: begin
          if (out_ready && fresh_s) begin
            // Handshake and a new capture on the same edge: stay valid.
            pc_byte_r    <= value_s[23:16];
            wd_half_r    <= value_s[15:0];
            last_r       <= value_s;
            last_valid_r <= 1'b1;
            out_valid_r  <= 1'b1;
            state_r      <= HOLD;
          end else if (out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= COLLECT;
          end else begin
            // Held value stays; a fresh confirmation here is dropped.
            state_r <= HOLD;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          state_r     <= COLLECT;
        end
      endcase
    end
  end

  // Sticky flags; a new event on the clearing edge still sets its flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_r       <= 1'b0;
      err_digit_r <= 6'd0;
      overrun_r   <= 1'b0;
    end else begin
      err_r       <= (err_r && !clr_flags) || sample_bad_s;
      err_digit_r <= (clr_flags ? 6'd0 : err_digit_r) |
                     ({6{sample_bad_s}} & ~legal_s);
      overrun_r   <= (overrun_r && !clr_flags) || overrun_ev_s;
    end
  end

  assign out_valid = out_valid_r;
  assign pc_byte   = pc_byte_r;
  assign wd_half   = wd_half_r;
  assign err       = err_r;
  assign err_digit = err_digit_r;
  assign overrun   = overrun_r;

endmodule

// File: tb/tb_seg7_readback.sv
// Bench for seg7_readback: two instances (STABLE_COUNT=3/CHANGE_ONLY=1 and
// STABLE_COUNT=2/CHANGE_ONLY=0) share the stimulus. A reference model that
// counts runs of identical samples predicts each capture and pushes it to a
// per-instance queue; a monitor on the falling edge compares flags and
// pops/compares held data whenever the instance presents out_valid.
module tb_seg7_readback;

  localparam logic [23:0] V1 = 24'h1CBEEF;
  localparam logic [23:0] V2 = 24'h1CBEE0;
  localparam logic [23:0] V3 = 24'h201234;
  localparam logic [23:0] V4 = 24'h0A5A5A;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        sample_en = 1'b0;
  logic [6:0]  hex5 = 7'h7f, hex4 = 7'h7f, hex3 = 7'h7f;
  logic [6:0]  hex2 = 7'h7f, hex1 = 7'h7f, hex0 = 7'h7f;
  logic        out_ready = 1'b0;
  logic        clr_flags = 1'b0;

  logic        valid_a, valid_b, err_a, err_b, ovr_a, ovr_b;
  logic [7:0]  pc_a, pc_b;
  logic [15:0] wd_a, wd_b;
  logic [5:0]  ed_a, ed_b;

  int n_checks = 0;
  int n_pass   = 0;
  bit mon_on   = 1'b0;

  logic [6:0]  tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                            7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                            7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
                            7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
  logic [23:0] pool [4] = '{V1, V2, V3, V4};
  int          stab [2] = '{3, 2};
  bit          chg  [2] = '{1'b1, 1'b0};

  // Reference model state (state after the coming clock edge).
  logic [41:0] m_prev [2];
  bit          m_prev_ok [2];
  int          m_run [2];
  logic [23:0] m_last [2];
  bit          m_last_ok [2];
  bit          m_pend [2];
  bit          m_err [2];
  logic [5:0]  m_errd [2];
  bit          m_ovr [2];
  // Expected DUT state as of the most recent clock edge.
  bit          e_valid [2];
  bit          e_err [2];
  logic [5:0]  e_errd [2];
  bit          e_ovr [2];
  logic [23:0] q0 [$];
  logic [23:0] q1 [$];

  seg7_readback #(.STABLE_COUNT(3), .CHANGE_ONLY(1'b1)) dut_a (
    .clock(clock), .reset(reset), .sample_en(sample_en),
    .HEX5(hex5), .HEX4(hex4), .HEX3(hex3), .HEX2(hex2), .HEX1(hex1), .HEX0(hex0),
    .out_ready(out_ready), .clr_flags(clr_flags), .out_valid(valid_a),
    .pc_byte(pc_a), .wd_half(wd_a), .err(err_a), .err_digit(ed_a), .overrun(ovr_a)
  );

  seg7_readback #(.STABLE_COUNT(2), .CHANGE_ONLY(1'b0)) dut_b (
    .clock(clock), .reset(reset), .sample_en(sample_en),
    .HEX5(hex5), .HEX4(hex4), .HEX3(hex3), .HEX2(hex2), .HEX1(hex1), .HEX0(hex0),
    .out_ready(out_ready), .clr_flags(clr_flags), .out_valid(valid_b),
    .pc_byte(pc_b), .wd_half(wd_b), .err(err_b), .err_digit(ed_b), .overrun(ovr_b)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [41:0] enc(input logic [23:0] val);
    logic [41:0] r;
    for (int d = 0; d < 6; d++) r[d*7 +: 7] = tab[val[d*4 +: 4]];
    return r;
  endfunction

  function automatic logic [6:0] rand_bad();
    logic [6:0] c;
    c = 7'($urandom_range(0, 127));
    for (int n = 0; n < 16; n++) if (tab[n] == c) c = 7'h7f;
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_prev[i] = 42'd0; m_prev_ok[i] = 1'b0; m_run[i] = 0;
      m_last[i] = 24'd0; m_last_ok[i] = 1'b0; m_pend[i] = 1'b0;
      m_err[i] = 1'b0; m_errd[i] = 6'd0; m_ovr[i] = 1'b0;
      e_valid[i] = 1'b0; e_err[i] = 1'b0; e_errd[i] = 6'd0; e_ovr[i] = 1'b0;
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic commit();
    for (int i = 0; i < 2; i++) begin
      e_valid[i] = m_pend[i]; e_err[i] = m_err[i];
      e_errd[i]  = m_errd[i]; e_ovr[i] = m_ovr[i];
    end
  endtask

  // Predict the effect of the coming edge for instance i.
  task automatic step(input int i, input bit se, input logic [41:0] v,
                      input bit rdy, input bit clr);
    logic [5:0]  bad;
    logic [23:0] val;
    bit conf, fresh, ovr_ev, hs, found;
    bad = 6'd0; val = 24'd0; conf = 1'b0; ovr_ev = 1'b0;
    hs = m_pend[i] && rdy;
    if (se) begin
      for (int d = 0; d < 6; d++) begin
        found = 1'b0;
        for (int n = 0; n < 16; n++) begin
          if (tab[n] == v[d*7 +: 7]) begin
            found = 1'b1;
            val[d*4 +: 4] = 4'(n);
          end
        end
        bad[d] = !found;
      end
      if (bad != 6'd0) begin
        m_run[i] = 0;
        m_prev_ok[i] = 1'b0;
      end else begin
        if (m_prev_ok[i] && v == m_prev[i]) begin
          m_run[i]++;
        end else begin
          m_run[i] = 1;
          m_prev[i] = v;
          m_prev_ok[i] = 1'b1;
        end
        conf = (m_run[i] == stab[i]);
      end
    end
    fresh = conf && (!chg[i] || !m_last_ok[i] || val != m_last[i]);
    if (fresh && m_pend[i] && !rdy) begin
      ovr_ev = 1'b1;
    end else if (fresh) begin
      if (i == 0) q0.push_back(val); else q1.push_back(val);
      m_pend[i] = 1'b1;
      m_last[i] = val;
      m_last_ok[i] = 1'b1;
    end else if (hs) begin
      m_pend[i] = 1'b0;
    end
    if (clr) begin
      m_err[i] = 1'b0; m_errd[i] = 6'd0; m_ovr[i] = 1'b0;
    end
    m_err[i]  = m_err[i] || (bad != 6'd0);
    m_errd[i] = m_errd[i] | bad;
    m_ovr[i]  = m_ovr[i] || ovr_ev;
  endtask

  task automatic cycle(input bit se, input logic [41:0] v, input bit rdy, input bit clr);
    @(posedge clock);
    #1;
    commit();
    sample_en = se;
    {hex5, hex4, hex3, hex2, hex1, hex0} = v;
    out_ready = rdy;
    clr_flags = clr;
    step(0, se, v, rdy, clr);
    step(1, se, v, rdy, clr);
  endtask

  task automatic feed(input logic [23:0] val, input int n, input bit rdy);
    for (int k = 0; k < n; k++) cycle(1'b1, enc(val), rdy, 1'b0);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int k = 0; k < n; k++) cycle(1'b0, enc(V4), rdy, 1'b0);
  endtask

  // Reset pulsed between edges; outputs must clear before the next edge.
  task automatic pulse_reset();
    @(posedge clock);
    #1;
    commit();
    sample_en = 1'b0; out_ready = 1'b0; clr_flags = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("rst.a.valid", valid_a, 0); chk("rst.a.pc", pc_a, 0);
    chk("rst.a.wd", wd_a, 0);       chk("rst.a.err", err_a, 0);
    chk("rst.a.errd", ed_a, 0);     chk("rst.a.ovr", ovr_a, 0);
    chk("rst.b.valid", valid_b, 0); chk("rst.b.pc", pc_b, 0);
    chk("rst.b.wd", wd_b, 0);       chk("rst.b.ovr", ovr_b, 0);
    #1 reset = 1'b0;
    model_reset();
  endtask

  task automatic mon(input int i, input logic v, input logic [23:0] data,
                     input logic e, input logic [5:0] ed, input logic o);
    string p;
    int sz;
    logic [23:0] exp;
    p = (i == 0) ? "a" : "b";
    chk({p, ".out_valid"}, v, e_valid[i]);
    chk({p, ".err"}, e, e_err[i]);
    chk({p, ".err_digit"}, ed, e_errd[i]);
    chk({p, ".overrun"}, o, e_ovr[i]);
    if (v) begin
      sz = (i == 0) ? q0.size() : q1.size();
      if (sz == 0) begin
        chk({p, ".expected_reading_exists"}, 0, 1);
      end else begin
        exp = (i == 0) ? q0[0] : q1[0];
        chk({p, ".data"}, data, exp);
        if (out_ready) begin
          if (i == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
      end
    end
  endtask

  // Monitor: compare on the falling edge, away from DUT updates.
  always @(negedge clock) begin
    if (!reset && mon_on) begin
      mon(0, valid_a, {pc_a, wd_a}, err_a, ed_a, ovr_a);
      mon(1, valid_b, {pc_b, wd_b}, err_b, ed_b, ovr_b);
    end
  end

  initial begin
    logic [41:0] v;
    logic [23:0] val;
    int k;
    int d;
    model_reset();
    #12 reset = 1'b0;
    chk("init.a.valid", valid_a, 0);
    chk("init.a.pc", pc_a, 0);
    chk("init.a.wd", wd_a, 0);
    mon_on = 1'b1;

    // 1C/BEEF held for three samples, then accepted later.
    feed(V1, 3, 1'b0);
    idle(3, 1'b0);
    idle(1, 1'b1);
    // Blank on HEX3 restarts stability; same value again (CHANGE_ONLY differs).
    v = enc(V1);
    v[3*7 +: 7] = 7'b1111111;
    cycle(1'b1, v, 1'b0, 1'b0);
    feed(V1, 3, 1'b1);
    idle(2, 1'b1);
    // Error and clear on the same edge: error wins; then a plain clear.
    cycle(1'b1, v, 1'b1, 1'b1);
    cycle(1'b0, enc(V4), 1'b1, 1'b1);
    // HEX0 changes after two stable samples.
    feed(V4, 1, 1'b1);
    feed(V1, 2, 1'b1);
    feed(V2, 3, 1'b1);
    idle(2, 1'b1);
    // Overrun while holding, then reset mid-hold.
    feed(V1, 3, 1'b0);
    idle(1, 1'b0);
    feed(V3, 3, 1'b0);
    idle(2, 1'b0);
    cycle(1'b1, v, 1'b0, 1'b0);
    pulse_reset();
    // New confirmation on the handshake edge.
    feed(V1, 3, 1'b0);
    idle(2, 1'b0);
    feed(V3, 2, 1'b0);
    feed(V3, 1, 1'b1);
    idle(1, 1'b0);
    idle(1, 1'b1);
    cycle(1'b0, enc(V4), 1'b0, 1'b1);

    // Randomized runs over a small value pool with gaps, errors and clears.
    for (int it = 0; it < 250; it++) begin
      val = pool[$urandom_range(0, 3)];
      k = $urandom_range(1, 4);
      for (int r = 0; r < k; r++) begin
        v = enc(val);
        if ($urandom_range(0, 11) == 0) begin
          d = $urandom_range(0, 5);
          v[d*7 +: 7] = rand_bad();
        end
        cycle($urandom_range(0, 2) != 0, v, $urandom_range(0, 2) == 0,
              $urandom_range(0, 15) == 0);
      end
    end

    idle(4, 1'b1);
    @(posedge clock);
    #1;
    commit();
    chk("a.queue_drained", q0.size(), 0);
    chk("b.queue_drained", q1.size(), 0);
    mon_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
